l1_tag_data_array: RTL and testbench
====================================

# l1_tag_data_array

Direct-mapped L1 storage core: a per-line tag/valid/dirty store with hit/miss arbitration, plus a 16-bit byte-enable data RAM. It sits under the L1 cache controller. The controller supplies lookup addresses, refill commands and RAM write strobes; this block returns hit/miss, line-select indices and read data. It holds no bus logic and no controller state machine.

## Interface
- ENTRY_NUM, 8, number of cache lines; ENTRYSEL_WIDTH = max(1, clog2(ENTRY_NUM))
- TAG_WID, 14, tag width
- WBACK_ENABLE, 0, 1 enables dirty-bit tracking
- DATA_WIDTH, 16, RAM word width; must be a multiple of 8; BSEL = DATA_WIDTH/8
- CACHE_DEPTH, 1024, RAM depth in words; RADDR_WIDTH = clog2(CACHE_DEPTH)+clog2(BSEL)

Ports:
- clk  in  1  the single clock
- rst  in  1  reset, synchronous, active-high
- entry_read  in  1  lookup request
- address_tag  in  TAG_WID  lookup tag
- address_ent  in  ENTRYSEL_WIDTH  lookup line index
- valid_clear  in  1  flush all lines
- refill_tag  in  TAG_WID  tag written on refill
- line_refill  in  1  commit refill of line address_ent
- entry_wthru  in  1  write-through hit notification
- entry_wback  in  1  write-back hit; marks the line dirty
- writeback_ok  in  1  dirty victim written back; refill permitted
- line_miss  out  1  lookup missed
- entry_dirty  out  1  selected line is valid and dirty
- entry_replace_sel  out  ENTRYSEL_WIDTH  victim line index for refill
- entry_select_addr  out  ENTRYSEL_WIDTH  line index for data access
- raddr  in  RADDR_WIDTH  RAM read byte address
- waddr  in  RADDR_WIDTH  RAM write byte address
- di  in  DATA_WIDTH  RAM write data
- we  in  1  RAM write enable
- bsel  in  BSEL  per-byte write enable; bit i covers di[8i+7:8i]
- dato  out  DATA_WIDTH  RAM read data, registered

## Operation
- State per line: valid, dirty and tag[TAG_WID]. Reset clears all valid and dirty bits; tag contents after reset are don't-care.
- Lookup is combinational.
  - hit = valid[address_ent] & (tag[address_ent] == address_tag).
  - line_miss = entry_read & !hit. It is 0 when entry_read = 0.
- Direct-mapped: entry_select_addr = entry_replace_sel = address_ent.
- entry_dirty = WBACK_ENABLE & valid[address_ent] & dirty[address_ent].
- Refill, at the clock edge when line_refill = 1:
  - tag[address_ent] <= refill_tag; valid <= 1; dirty <= 0.
  - If WBACK_ENABLE = 1 and the line is dirty, the refill commits only when writeback_ok = 1. Otherwise it is ignored.
- entry_wback, when WBACK_ENABLE = 1 and hit = 1, sets dirty[address_ent]. When WBACK_ENABLE = 0, entry_wback is ignored.
- entry_wthru changes no state.
- valid_clear synchronously clears every valid and dirty bit.
- Priority: rst > valid_clear > line_refill > entry_wback.
- Data RAM:
  - Word index = byte address >> clog2(BSEL); the low address bits are ignored.
  - On a clock edge with we = 1, each byte whose bsel bit is set is written from the matching di byte.
  - Read: dato <= mem[raddr word] every clock.
  - Same-word read and write in one cycle returns the old data (read-first).
  - The RAM is not reset; contents are undefined until written.
  - The RAM maps to block RAM.

## Timing
- Outputs after reset:
  - line_miss = entry_read (all lines invalid).
  - entry_dirty = 0.
  - select and replace indices follow address_ent.
  - dato holds the previous value until the next clock.
- Tag lookup: 0-cycle latency. A refill committed at edge N makes hit = 1 combinationally from edge N onward for a matching address.
- RAM read latency is 1 cycle: raddr sampled at edge N appears on dato after edge N.
- A RAM write at edge N is visible to a read sampled at edge N+1.

## Test plan
- Reset, then entry_read = 1, address_ent = 3, address_tag = 0x0ABC -> line_miss = 1. Then pulse line_refill with refill_tag = 0x0ABC -> line_miss = 0 next cycle. With address_tag = 0x0ABD -> line_miss = 1.
- Refill lines 0..7 with distinct tags, pulse valid_clear -> every lookup misses. Assert valid_clear and line_refill together -> the line stays invalid.
- WBACK_ENABLE = 1: hit on line 2, pulse entry_wback -> entry_dirty = 1. Refill line 2 with writeback_ok = 0 -> tag unchanged. Refill again with writeback_ok = 1 -> new tag, entry_dirty = 0.
- RAM: write 0xA5A5 to word 5 with bsel = 2'b11, then write di = 0x3C3C with bsel = 2'b10 -> read word 5 gives 0x3CA5 one cycle after raddr is applied.
- RAM read-first: read and write word 7 in the same cycle -> dato shows the old value; next cycle it shows the new value.
- entry_read = 0 with any address -> line_miss = 0. Apply a synchronous rst pulse mid-sequence -> all lines invalid on the next edge.

Source files
------------

// File: rtl/l1_tag_data_array.sv
// Direct-mapped L1 storage core: per-line valid/dirty/tag store with combinational
// hit/miss lookup, plus a byte-enable read-first data RAM with a registered read port.
module l1_tag_data_array #(
  parameter int ENTRY_NUM      = 8,
  parameter int TAG_WID        = 14,
  parameter int WBACK_ENABLE   = 0,
  parameter int DATA_WIDTH     = 16,
  parameter int CACHE_DEPTH    = 1024,
  parameter int ENTRYSEL_WIDTH = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
  parameter int BSEL           = DATA_WIDTH / 8,
  parameter int RADDR_WIDTH    = $clog2(CACHE_DEPTH) + $clog2(BSEL)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      entry_read,
  input  logic [TAG_WID-1:0]        address_tag,
  input  logic [ENTRYSEL_WIDTH-1:0] address_ent,
  input  logic                      valid_clear,
  input  logic [TAG_WID-1:0]        refill_tag,
  input  logic                      line_refill,
  input  logic                      entry_wthru,
  input  logic                      entry_wback,
  input  logic                      writeback_ok,
  output logic                      line_miss,
  output logic                      entry_dirty,
  output logic [ENTRYSEL_WIDTH-1:0] entry_replace_sel,
  output logic [ENTRYSEL_WIDTH-1:0] entry_select_addr,
  input  logic [RADDR_WIDTH-1:0]    raddr,
  input  logic [RADDR_WIDTH-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]     di,
  input  logic                      we,
  input  logic [BSEL-1:0]           bsel,
  output logic [DATA_WIDTH-1:0]     dato
);

  localparam int BOFF = $clog2(BSEL);
  localparam bit WB   = (WBACK_ENABLE != 0);

  logic [ENTRY_NUM-1:0] valid;
  logic [ENTRY_NUM-1:0] dirty;
  logic [TAG_WID-1:0]   tag_mem [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] mem [CACHE_DEPTH];

  logic hit;
  logic line_dirty;
  logic refill_commit;

  // Write-through hits carry no state in this block.
  logic unused_wthru;
  assign unused_wthru = entry_wthru;

  assign hit        = valid[address_ent] && (tag_mem[address_ent] == address_tag);
  assign line_dirty = WB && valid[address_ent] && dirty[address_ent];

  assign line_miss         = entry_read && !hit;
  assign entry_dirty       = line_dirty;
  assign entry_select_addr = address_ent;
  assign entry_replace_sel = address_ent;

  // A dirty victim may only be replaced once the controller confirms the writeback.
  assign refill_commit = line_refill && (!line_dirty || writeback_ok) && !valid_clear;

  always_ff @(posedge clk) begin
    if (rst || valid_clear) begin
      valid <= '0;
      dirty <= '0;
    end else if (refill_commit) begin
      valid[address_ent] <= 1'b1;
      dirty[address_ent] <= 1'b0;
    end else if (WB && entry_wback && hit && !line_refill) begin
      dirty[address_ent] <= 1'b1;
    end
  end

  // Tag storage needs no reset: valid gates every use of it.
  always_ff @(posedge clk) begin
    if (!rst && refill_commit) begin
      tag_mem[address_ent] <= refill_tag;
    end
  end

  // Read-first byte-enable RAM; low byte-offset address bits are dropped.
  always_ff @(posedge clk) begin
    dato <= mem[raddr[RADDR_WIDTH-1:BOFF]];
    if (we) begin
      for (int b = 0; b < BSEL; b++) begin
        if (bsel[b]) begin
          mem[waddr[RADDR_WIDTH-1:BOFF]][8*b +: 8] <= di[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_l1_tag_data_array.sv
// Directed bench for l1_tag_data_array: one write-through and one write-back
// instance share the same stimulus and are checked against hand-computed values.
module tb_l1_tag_data_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        entry_read;
  logic [13:0] address_tag;
  logic [2:0]  address_ent;
  logic        valid_clear;
  logic [13:0] refill_tag;
  logic        line_refill;
  logic        entry_wthru;
  logic        entry_wback;
  logic        writeback_ok;
  logic [10:0] raddr;
  logic [10:0] waddr;
  logic [15:0] di;
  logic        we;
  logic [1:0]  bsel;

  logic        miss_wt, dirty_wt, miss_wb, dirty_wb;
  logic [2:0]  rep_wt, sel_wt, rep_wb, sel_wb;
  logic [15:0] dato_wt, dato_wb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_tag_data_array #(.WBACK_ENABLE(0)) u_wt (
    .clk(clk), .rst(rst), .entry_read(entry_read), .address_tag(address_tag),
    .address_ent(address_ent), .valid_clear(valid_clear), .refill_tag(refill_tag),
    .line_refill(line_refill), .entry_wthru(entry_wthru), .entry_wback(entry_wback),
    .writeback_ok(writeback_ok), .line_miss(miss_wt), .entry_dirty(dirty_wt),
    .entry_replace_sel(rep_wt), .entry_select_addr(sel_wt), .raddr(raddr),
    .waddr(waddr), .di(di), .we(we), .bsel(bsel), .dato(dato_wt)
  );

  l1_tag_data_array #(.WBACK_ENABLE(1)) u_wb (
    .clk(clk), .rst(rst), .entry_read(entry_read), .address_tag(address_tag),
    .address_ent(address_ent), .valid_clear(valid_clear), .refill_tag(refill_tag),
    .line_refill(line_refill), .entry_wthru(entry_wthru), .entry_wback(entry_wback),
    .writeback_ok(writeback_ok), .line_miss(miss_wb), .entry_dirty(dirty_wb),
    .entry_replace_sel(rep_wb), .entry_select_addr(sel_wb), .raddr(raddr),
    .waddr(waddr), .di(di), .we(we), .bsel(bsel), .dato(dato_wb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [2:0] ent, input logic [13:0] t);
    address_ent = ent;
    refill_tag  = t;
    line_refill = 1'b1;
    step();
    line_refill = 1'b0;
  endtask

  task automatic lookup(input logic [2:0] ent, input logic [13:0] t);
    entry_read  = 1'b1;
    address_ent = ent;
    address_tag = t;
    #1;
  endtask

  initial begin
    rst = 1'b1; entry_read = 0; address_tag = '0; address_ent = '0; valid_clear = 0;
    refill_tag = '0; line_refill = 0; entry_wthru = 0; entry_wback = 0; writeback_ok = 0;
    raddr = '0; waddr = '0; di = '0; we = 0; bsel = '0;
    step(); step();
    rst = 1'b0;

    // Reset state and first refill
    lookup(3'd3, 14'h0ABC);
    chk("rst_miss_wt", 32'(miss_wt), 32'd1);
    chk("rst_miss_wb", 32'(miss_wb), 32'd1);
    chk("rst_dirty_wb", 32'(dirty_wb), 32'd0);
    chk("sel_idx", 32'(sel_wt), 32'd3);
    chk("rep_idx", 32'(rep_wb), 32'd3);
    refill(3'd3, 14'h0ABC);
    #1;
    chk("hit_after_refill_wt", 32'(miss_wt), 32'd0);
    chk("hit_after_refill_wb", 32'(miss_wb), 32'd0);
    lookup(3'd3, 14'h0ABD);
    chk("tag_mismatch", 32'(miss_wt), 32'd1);
    entry_read = 1'b0;
    #1;
    chk("no_read_no_miss", 32'(miss_wt), 32'd0);

    // Fill every line, then flush
    for (int i = 0; i < 8; i++) refill(3'(i), 14'h0100 + 14'(i));
    for (int i = 0; i < 8; i++) begin
      lookup(3'(i), 14'h0100 + 14'(i));
      chk("fill_hit", 32'(miss_wt), 32'd0);
    end
    lookup(3'd6, 14'h0105);
    chk("fill_wrong_tag", 32'(miss_wt), 32'd1);
    valid_clear = 1'b1;
    step();
    valid_clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lookup(3'(i), 14'h0100 + 14'(i));
      chk("flush_miss", 32'(miss_wb), 32'd1);
    end
    valid_clear = 1'b1;
    refill(3'd4, 14'h0104);
    valid_clear = 1'b0;
    lookup(3'd4, 14'h0104);
    chk("clear_beats_refill", 32'(miss_wt), 32'd1);

    // Dirty tracking and gated refill
    refill(3'd2, 14'h0222);
    lookup(3'd2, 14'h0222);
    chk("wb_line_hit", 32'(miss_wb), 32'd0);
    entry_wthru = 1'b1;
    step();
    entry_wthru = 1'b0;
    #1;
    chk("wthru_no_dirty", 32'(dirty_wb), 32'd0);
    entry_wback = 1'b1;
    step();
    entry_wback = 1'b0;
    #1;
    chk("wback_dirty_wb", 32'(dirty_wb), 32'd1);
    chk("wback_ignored_wt", 32'(dirty_wt), 32'd0);
    writeback_ok = 1'b0;
    refill(3'd2, 14'h0333);
    lookup(3'd2, 14'h0222);
    chk("blocked_refill_wb", 32'(miss_wb), 32'd0);
    chk("blocked_dirty_wb", 32'(dirty_wb), 32'd1);
    chk("free_refill_wt", 32'(miss_wt), 32'd1);
    writeback_ok = 1'b1;
    refill(3'd2, 14'h0333);
    writeback_ok = 1'b0;
    lookup(3'd2, 14'h0333);
    chk("ok_refill_wb", 32'(miss_wb), 32'd0);
    chk("ok_refill_clean", 32'(dirty_wb), 32'd0);
    lookup(3'd2, 14'h0444);
    entry_wback = 1'b1;
    step();
    entry_wback = 1'b0;
    #1;
    chk("wback_on_miss", 32'(dirty_wb), 32'd0);

    // RAM byte enables
    we = 1'b1; waddr = 11'd10; di = 16'hA5A5; bsel = 2'b11;
    step();
    di = 16'h3C3C; bsel = 2'b10;
    step();
    we = 1'b0; raddr = 11'd10;
    step();
    chk("ram_bsel_wt", 32'(dato_wt), 32'h3CA5);
    chk("ram_bsel_wb", 32'(dato_wb), 32'h3CA5);
    raddr = 11'd11;
    step();
    chk("ram_low_bit_ignored", 32'(dato_wt), 32'h3CA5);

    // RAM read-first
    we = 1'b1; waddr = 11'd14; di = 16'h1111; bsel = 2'b11;
    step();
    raddr = 11'd14; di = 16'h2222;
    step();
    we = 1'b0;
    chk("ram_read_first_old", 32'(dato_wt), 32'h1111);
    step();
    chk("ram_read_first_new", 32'(dato_wt), 32'h2222);
    raddr = 11'd10;
    step();
    chk("ram_word5_intact", 32'(dato_wb), 32'h3CA5);

    // Mid-sequence reset
    refill(3'd1, 14'h0055);
    lookup(3'd1, 14'h0055);
    chk("pre_rst_hit", 32'(miss_wt), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_miss_wt", 32'(miss_wt), 32'd1);
    chk("post_rst_miss_wb", 32'(miss_wb), 32'd1);
    lookup(3'd3, 14'h0ABC);
    chk("post_rst_line3", 32'(miss_wt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
